// File: rtl/float_align_unit_if.sv
// Operand/result handshake bundle for the FP adder alignment stage.
// Latency: n/a (wiring only); out_sticky exists only with ALIGN_STICKY_EN.
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
interface float_align_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_exp;
  logic [23:0] out_mant_big;
  logic [23:0] out_mant_small;
  logic        out_sign_big;
  logic        out_sign_small;
  logic        out_swapped;
`ifdef ALIGN_STICKY_EN
  logic        out_sticky;
`endif

  // Environment side: supplies operands and consumes results.
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_exp, out_mant_big, out_mant_small,
           out_sign_big, out_sign_small, out_swapped
`ifdef ALIGN_STICKY_EN
    , input out_sticky
`endif
  );

  // Alignment unit side.
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_exp, out_mant_big, out_mant_small,
           out_sign_big, out_sign_small, out_swapped
`ifdef ALIGN_STICKY_EN
    , output out_sticky
`endif
  );
endinterface

// File: rtl/float_align_unit.sv
// Pre-normalization for the SP FP adder: unpack, order by magnitude, right-align small mantissa.
// Latency: 1 cycle for d==0 or d>=MAX_SHIFT, else 1+ceil(d/SHIFT_STEP); one op in flight.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Optional: ALIGN_STICKY_EN.
module float_align_unit #(
  parameter int SHIFT_STEP = 1,   // legal: 1, 2, 4, 8
  parameter int MAX_SHIFT  = 25
) (
  input logic         clk,
  input logic         rst_n,
  float_align_if.slave io
);

  typedef enum logic [1:0] {IDLE, ALIGN, DONE} state_t;

  localparam logic [7:0] STEP_W = 8'(SHIFT_STEP);
  localparam logic [7:0] MAX_W  = 8'(MAX_SHIFT);

  state_t state, state_nxt;

  // Unpacked operands. A zero exponent field is a denormal and behaves as
  // exponent 1 without the hidden bit, so ordering and shift distance both
  // use the effective exponent; that same effective value is what goes out
  // as the common exponent.
  logic [7:0]  exp_a, exp_b;
  logic [23:0] mant_a, mant_b;
  logic        a_big;
  logic [7:0]  in_exp_big, in_exp_small, diff;
  logic [23:0] in_mant_big, in_mant_small;
  logic        in_sign_big, in_sign_small;
  logic        flush;

  assign exp_a  = (io.in_a[30:23] == 8'd0) ? 8'd1 : io.in_a[30:23];
  assign exp_b  = (io.in_b[30:23] == 8'd0) ? 8'd1 : io.in_b[30:23];
  assign mant_a = {(io.in_a[30:23] != 8'd0), io.in_a[22:0]};
  assign mant_b = {(io.in_b[30:23] != 8'd0), io.in_b[22:0]};

  // Ties (equal magnitude) keep A as the big operand.
  assign a_big = (exp_a > exp_b) || ((exp_a == exp_b) && (mant_a >= mant_b));

  assign in_exp_big    = a_big ? exp_a : exp_b;
  assign in_exp_small  = a_big ? exp_b : exp_a;
  assign in_mant_big   = a_big ? mant_a : mant_b;
  assign in_mant_small = a_big ? mant_b : mant_a;
  assign in_sign_big   = a_big ? io.in_a[31] : io.in_b[31];
  assign in_sign_small = a_big ? io.in_b[31] : io.in_a[31];
  assign diff          = in_exp_big - in_exp_small;
  assign flush         = (diff >= MAX_W);

  // Working registers for the operation in flight.
  logic [7:0]  exp_r;
  logic [23:0] big_r, small_r;
  logic        sign_big_r, sign_small_r, swapped_r;
  logic [7:0]  cnt_r;

  // One iteration of the shifter: move by at most SHIFT_STEP bits.
  logic [7:0]  step;
  logic [23:0] shifted;
  logic [7:0]  cnt_dec;

  assign step    = (cnt_r < STEP_W) ? cnt_r : STEP_W;
  assign shifted = small_r >> step;
  assign cnt_dec = cnt_r - step;

`ifdef ALIGN_STICKY_EN
  logic        sticky_r;
  logic [23:0] lost;
  // Bits that fall off the right edge this iteration.
  assign lost = small_r & ((24'd1 << step) - 24'd1);
`endif

  logic accept;
  logic enter_done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and accept decode. A result leaving DONE always returns to
  // IDLE first, so a pending operand waits one bubble cycle.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (io.in_valid) begin
          accept = 1'b1;
          if (diff == 8'd0 || flush) state_nxt = DONE;
          else                       state_nxt = ALIGN;
        end
      end
      ALIGN: begin
        if (cnt_dec == 8'd0) state_nxt = DONE;
      end
      DONE: begin
        if (io.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_done  = (state_nxt == DONE) && (state != DONE);
  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);

  // Capture operands on accept, then shift the small mantissa each ALIGN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_r        <= '0;
      big_r        <= '0;
      small_r      <= '0;
      sign_big_r   <= 1'b0;
      sign_small_r <= 1'b0;
      swapped_r    <= 1'b0;
      cnt_r        <= '0;
`ifdef ALIGN_STICKY_EN
      sticky_r     <= 1'b0;
`endif
    end else if (accept) begin
      exp_r        <= in_exp_big;
      big_r        <= in_mant_big;
      small_r      <= in_mant_small;
      sign_big_r   <= in_sign_big;
      sign_small_r <= in_sign_small;
      swapped_r    <= !a_big;
      cnt_r        <= diff;
`ifdef ALIGN_STICKY_EN
      sticky_r     <= 1'b0;
`endif
    end else if (state == ALIGN) begin
      small_r      <= shifted;
      cnt_r        <= cnt_dec;
`ifdef ALIGN_STICKY_EN
      sticky_r     <= sticky_r | (|lost);
`endif
    end
  end

  // Result registers load only on entry to DONE: straight from the unpacked
  // operands for the single-cycle cases, otherwise from the last shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.out_exp        <= '0;
      io.out_mant_big   <= '0;
      io.out_mant_small <= '0;
      io.out_sign_big   <= 1'b0;
      io.out_sign_small <= 1'b0;
      io.out_swapped    <= 1'b0;
`ifdef ALIGN_STICKY_EN
      io.out_sticky     <= 1'b0;
`endif
    end else if (enter_done) begin
      if (state == IDLE) begin
        io.out_exp        <= in_exp_big;
        io.out_mant_big   <= in_mant_big;
        io.out_mant_small <= flush ? 24'd0 : in_mant_small;
        io.out_sign_big   <= in_sign_big;
        io.out_sign_small <= in_sign_small;
        io.out_swapped    <= !a_big;
`ifdef ALIGN_STICKY_EN
        io.out_sticky     <= flush & (|in_mant_small);
`endif
      end else begin
        io.out_exp        <= exp_r;
        io.out_mant_big   <= big_r;
        io.out_mant_small <= shifted;
        io.out_sign_big   <= sign_big_r;
        io.out_sign_small <= sign_small_r;
        io.out_swapped    <= swapped_r;
`ifdef ALIGN_STICKY_EN
        io.out_sticky     <= sticky_r | (|lost);
`endif
      end
    end
  end

endmodule

// File: tb/tb_float_align_unit.sv
// Directed bench for float_align_unit (SHIFT_STEP=1, MAX_SHIFT=25).
// Latency counted in rising edges from the accept edge to out_valid.
// Exercises stall, bubble, mid-operation reset and, with ALIGN_STICKY_EN, sticky.
module tb_float_align_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   lat;
  int   saw_valid;

  float_align_if io ();

  float_align_unit #(.SHIFT_STEP(1), .MAX_SHIFT(25)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one operand pair, count edges until out_valid (bounded).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int n);
    @(negedge clk);
    chk("in_ready_before_accept", 32'(io.in_ready), 32'd1);
    io.in_a = a;
    io.in_b = b;
    io.in_valid = 1'b1;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    n = 1;
    while (!io.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    io.in_valid = 1'b0;
    io.in_a = '0;
    io.in_b = '0;
    io.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_in_ready", 32'(io.in_ready), 32'd1);
    chk("rst_out_exp", 32'(io.out_exp), 32'd0);
    chk("rst_big", 32'(io.out_mant_big), 32'd0);
    chk("rst_small", 32'(io.out_mant_small), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1.0 + 1.0: equal magnitude, no shift.
    run_op(32'h3F800000, 32'h3F800000, lat);
    chk("t1_latency", 32'(lat), 32'd1);
    chk("t1_exp", 32'(io.out_exp), 32'h7F);
    chk("t1_big", 32'(io.out_mant_big), 32'h800000);
    chk("t1_small", 32'(io.out_mant_small), 32'h800000);
    chk("t1_swapped", 32'(io.out_swapped), 32'd0);
    @(posedge clk); #1;
    chk("t1_back_idle", 32'(io.in_ready), 32'd1);

    // 1.0 vs 3.0: B larger, one-bit shift.
    run_op(32'h3F800000, 32'h40400000, lat);
    chk("t2_latency", 32'(lat), 32'd2);
    chk("t2_swapped", 32'(io.out_swapped), 32'd1);
    chk("t2_exp", 32'(io.out_exp), 32'h80);
    chk("t2_big", 32'(io.out_mant_big), 32'hC00000);
    chk("t2_small", 32'(io.out_mant_small), 32'h400000);
    @(posedge clk); #1;

    // d == 25: flushed without iterating.
    run_op(32'h3F800000, 32'h4C000000, lat);
    chk("t3_latency", 32'(lat), 32'd1);
    chk("t3_exp", 32'(io.out_exp), 32'h98);
    chk("t3_small", 32'(io.out_mant_small), 32'd0);
    chk("t3_big", 32'(io.out_mant_big), 32'h800000);
`ifdef ALIGN_STICKY_EN
    chk("t3_sticky", 32'(io.out_sticky), 32'd1);
`endif
    @(posedge clk); #1;

    // 4.0 vs -1.0 with downstream stalled; a new pair waits meanwhile.
    io.out_ready = 1'b0;
    run_op(32'h40800000, 32'hBF800000, lat);
    chk("t4_latency", 32'(lat), 32'd3);
    chk("t4_small", 32'(io.out_mant_small), 32'h200000);
    chk("t4_sign_small", 32'(io.out_sign_small), 32'd1);
    chk("t4_sign_big", 32'(io.out_sign_big), 32'd0);
    @(negedge clk);
    io.in_a = 32'h3F800000;
    io.in_b = 32'h3F800000;
    io.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", 32'(io.out_valid), 32'd1);
      chk("t4_hold_exp", 32'(io.out_exp), 32'h81);
      chk("t4_hold_small", 32'(io.out_mant_small), 32'h200000);
      chk("t4_hold_in_ready", 32'(io.in_ready), 32'd0);
    end
    @(negedge clk);
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_release_valid", 32'(io.out_valid), 32'd0);
    chk("t4_release_in_ready", 32'(io.in_ready), 32'd1);
    chk("t4_bubble_exp_held", 32'(io.out_exp), 32'h81);
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    chk("t4_next_valid", 32'(io.out_valid), 32'd1);
    chk("t4_next_exp", 32'(io.out_exp), 32'h7F);
    @(posedge clk); #1;

    // d == 20, reset in the third ALIGN cycle.
    @(negedge clk);
    io.in_a = 32'h3F800000;
    io.in_b = 32'h49800000;
    io.in_valid = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(io.out_valid), 32'd0);
    chk("t5_rst_exp", 32'(io.out_exp), 32'd0);
    chk("t5_rst_big", 32'(io.out_mant_big), 32'd0);
    chk("t5_rst_in_ready", 32'(io.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (io.out_valid) saw_valid = 1;
    end
    chk("t5_no_output", 32'(saw_valid), 32'd0);
    chk("t5_in_ready", 32'(io.in_ready), 32'd1);

    // Denormal vs smallest normal: both effective exponent 1, B larger.
    run_op(32'h00000001, 32'h00800000, lat);
    chk("t6_latency", 32'(lat), 32'd1);
    chk("t6_exp", 32'(io.out_exp), 32'd1);
    chk("t6_swapped", 32'(io.out_swapped), 32'd1);
    chk("t6_small", 32'(io.out_mant_small), 32'h000001);
    @(posedge clk); #1;

`ifdef ALIGN_STICKY_EN
    run_op(32'h3F800001, 32'h40000000, lat);
    chk("t7_swapped", 32'(io.out_swapped), 32'd1);
    chk("t7_small", 32'(io.out_mant_small), 32'h400000);
    chk("t7_sticky", 32'(io.out_sticky), 32'd1);
    @(posedge clk); #1;
    run_op(32'h3F800000, 32'h40000000, lat);
    chk("t8_small", 32'(io.out_mant_small), 32'h400000);
    chk("t8_sticky", 32'(io.out_sticky), 32'd0);
    @(posedge clk); #1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
